// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit -- fetch-stage program counter: advance, redirect, trap,
//                  misalign detection, boot/halt states and fetch counter.
// Revision: 1.0
// ============================================================================
module pc_fetch_unit #(
  parameter int unsigned XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0100,
  parameter int unsigned INC          = 4,
  parameter int unsigned ALIGN_BITS   = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_ready_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             trap_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pcplus_o,
  output logic             pc_valid_o,
  output logic             misalign_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [XLEN-1:0] RESET_PC   = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] TRAP_PC    = TRAP_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_arm_q;

  logic             w_target_misaligned;
  logic             w_accept;
  logic             w_event;
  logic             w_event_misalign;
  logic [XLEN-1:0]  w_event_pc;

  assign w_target_misaligned = |(redirect_target_i & ALIGN_MASK);
  assign w_accept            = fetch_ready_i & ~stall_i;

  // Trap beats redirect; a misaligned redirect is converted into a trap.
  assign w_event          = trap_i | redirect_i;
  assign w_event_misalign = ~trap_i & redirect_i & w_target_misaligned;
  assign w_event_pc       = (trap_i | w_target_misaligned) ? TRAP_PC : redirect_target_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      // The partial cycle in which reset releases does not count as BOOT.
      ST_BOOT: begin
        if (boot_arm_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_event) begin
          pc_d       = w_event_pc;
          misalign_d = w_event_misalign;
        end else begin
          if (w_accept) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (w_accept) begin
            pc_d = pc_q + INC_V;
          end
        end
      end
      ST_HALT: begin
        if (w_event) begin
          pc_d       = w_event_pc;
          misalign_d = w_event_misalign;
          state_d    = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
      boot_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
      boot_arm_q <= 1'b1;
    end
  end

  assign pc_o        = pc_q;
  assign pcplus_o    = pc_q + INC_V;
  assign pc_valid_o  = (state_q == ST_RUN);
  assign halted_o    = (state_q == ST_HALT);
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit -- directed bench for pc_fetch_unit (32-bit and 8-bit).
// Revision: 1.0
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_ni;
  logic        ready, stall, redirect, trap, halt, resume;
  logic [31:0] target;
  logic [31:0] pc, pcplus;
  logic        valid, mis, halted;
  logic [15:0] cnt;

  logic        ready8, redirect8, trap8;
  logic [7:0]  target8;
  logic [7:0]  pc8, pcplus8;
  logic        valid8, mis8, halted8;
  logic [1:0]  cnt8;

  int nchk;
  int nfail;

  pc_fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_ready_i(ready), .stall_i(stall),
    .redirect_i(redirect), .redirect_target_i(target), .trap_i(trap),
    .halt_i(halt), .resume_i(resume), .pc_o(pc), .pcplus_o(pcplus),
    .pc_valid_o(valid), .misalign_o(mis), .halted_o(halted), .fetch_cnt_o(cnt)
  );

  pc_fetch_unit #(.XLEN(8), .TRAP_VECTOR(64'h100), .CNT_W(2)) dut8 (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_ready_i(ready8), .stall_i(1'b0),
    .redirect_i(redirect8), .redirect_target_i(target8), .trap_i(trap8),
    .halt_i(1'b0), .resume_i(1'b0), .pc_o(pc8), .pcplus_o(pcplus8),
    .pc_valid_o(valid8), .misalign_o(mis8), .halted_o(halted8), .fetch_cnt_o(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ready = 1'b1; stall = 1'b0; redirect = 1'b0; trap = 1'b0;
    halt = 1'b0; resume = 1'b0; target = '0;
    ready8 = 1'b0; redirect8 = 1'b0; trap8 = 1'b0; target8 = '0;
    repeat (2) tick();
    nchk++; if (pc !== 32'h0) begin nfail++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h0); end
    nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b expected 0", valid); end
    nchk++; if (mis !== 1'b0) begin nfail++; $display("FAIL rst_mis: got %b expected 0", mis); end
    nchk++; if (halted !== 1'b0) begin nfail++; $display("FAIL rst_halted: got %b expected 0", halted); end
    nchk++; if (cnt !== 16'd0) begin nfail++; $display("FAIL rst_cnt: got %0d expected 0", cnt); end
    rst_ni = 1'b1;
    tick();
    nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL boot_valid: got %b expected 0", valid); end
    nchk++; if (pc !== 32'h0) begin nfail++; $display("FAIL boot_pc: got %h expected %h", pc, 32'h0); end
    tick();
    nchk++; if (valid !== 1'b1) begin nfail++; $display("FAIL first_valid: got %b expected 1", valid); end
    nchk++; if (pc !== 32'h0) begin nfail++; $display("FAIL first_pc: got %h expected %h", pc, 32'h0); end
    nchk++; if (pcplus !== 32'h4) begin nfail++; $display("FAIL first_pcplus: got %h expected %h", pcplus, 32'h4); end
    nchk++; if (cnt !== 16'd0) begin nfail++; $display("FAIL first_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_sequential();
    tick();
    nchk++; if (pc !== 32'h4 || cnt !== 16'd1) begin nfail++; $display("FAIL seq1: got pc=%h cnt=%0d expected pc=4 cnt=1", pc, cnt); end
    tick();
    nchk++; if (pc !== 32'h8 || cnt !== 16'd2) begin nfail++; $display("FAIL seq2: got pc=%h cnt=%0d expected pc=8 cnt=2", pc, cnt); end
    tick();
    nchk++; if (pc !== 32'hC || cnt !== 16'd3) begin nfail++; $display("FAIL seq3: got pc=%h cnt=%0d expected pc=c cnt=3", pc, cnt); end
  endtask

  task automatic test_stall();
    redirect = 1'b1; target = 32'h8;
    tick();
    nchk++; if (pc !== 32'h8 || cnt !== 16'd3) begin nfail++; $display("FAIL redir_nocount: got pc=%h cnt=%0d expected pc=8 cnt=3", pc, cnt); end
    redirect = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (pc !== 32'h8 || cnt !== 16'd3) begin nfail++; $display("FAIL stall_hold%0d: got pc=%h cnt=%0d expected pc=8 cnt=3", i, pc, cnt); end
    end
    stall = 1'b0;
    tick();
    nchk++; if (pc !== 32'hC || cnt !== 16'd4) begin nfail++; $display("FAIL stall_release: got pc=%h cnt=%0d expected pc=c cnt=4", pc, cnt); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect = 1'b1; target = 32'h40;
    tick();
    nchk++; if (pc !== 32'h40 || mis !== 1'b0) begin nfail++; $display("FAIL redir_stall: got pc=%h mis=%b expected pc=40 mis=0", pc, mis); end
    target = 32'h42;
    tick();
    nchk++; if (pc !== 32'h100 || mis !== 1'b1) begin nfail++; $display("FAIL redir_misalign: got pc=%h mis=%b expected pc=100 mis=1", pc, mis); end
    redirect = 1'b0;
    tick();
    nchk++; if (pc !== 32'h100 || mis !== 1'b0 || cnt !== 16'd4) begin nfail++; $display("FAIL misalign_pulse: got pc=%h mis=%b cnt=%0d expected pc=100 mis=0 cnt=4", pc, mis, cnt); end
  endtask

  task automatic test_trap_redirect();
    stall = 1'b0; trap = 1'b1; redirect = 1'b1; target = 32'h80;
    tick();
    nchk++; if (pc !== 32'h100 || mis !== 1'b0 || cnt !== 16'd4) begin nfail++; $display("FAIL trap_wins: got pc=%h mis=%b cnt=%0d expected pc=100 mis=0 cnt=4", pc, mis, cnt); end
    trap = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_halt();
    redirect = 1'b1; target = 32'h20;
    tick();
    nchk++; if (pc !== 32'h20) begin nfail++; $display("FAIL halt_setup: got %h expected %h", pc, 32'h20); end
    redirect = 1'b0; halt = 1'b1;
    tick();
    nchk++; if (halted !== 1'b1 || valid !== 1'b0 || pc !== 32'h20 || cnt !== 16'd5) begin nfail++; $display("FAIL halt_enter: got halted=%b valid=%b pc=%h cnt=%0d expected 1 0 20 5", halted, valid, pc, cnt); end
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++; if (halted !== 1'b1 || valid !== 1'b0 || pc !== 32'h20 || cnt !== 16'd5) begin nfail++; $display("FAIL halt_hold%0d: got halted=%b valid=%b pc=%h cnt=%0d expected 1 0 20 5", i, halted, valid, pc, cnt); end
    end
    resume = 1'b1;
    tick();
    nchk++; if (halted !== 1'b0 || valid !== 1'b1 || pc !== 32'h20) begin nfail++; $display("FAIL resume: got halted=%b valid=%b pc=%h expected 0 1 20", halted, valid, pc); end
    resume = 1'b0; ready = 1'b0; halt = 1'b1;
    tick();
    nchk++; if (halted !== 1'b1 || cnt !== 16'd5) begin nfail++; $display("FAIL halt_again: got halted=%b cnt=%0d expected 1 5", halted, cnt); end
    halt = 1'b0; redirect = 1'b1; target = 32'h60;
    tick();
    nchk++; if (halted !== 1'b0 || valid !== 1'b1 || pc !== 32'h60) begin nfail++; $display("FAIL halt_redirect: got halted=%b valid=%b pc=%h expected 0 1 60", halted, valid, pc); end
    redirect = 1'b0; ready = 1'b1;
    tick();
    nchk++; if (pc !== 32'h64 || cnt !== 16'd6) begin nfail++; $display("FAIL after_halt_adv: got pc=%h cnt=%0d expected 64 6", pc, cnt); end
  endtask

  task automatic test_redirect_halt();
    ready = 1'b0; redirect = 1'b1; halt = 1'b1; target = 32'h200;
    tick();
    nchk++; if (pc !== 32'h200 || halted !== 1'b0 || valid !== 1'b1) begin nfail++; $display("FAIL redir_halt: got pc=%h halted=%b valid=%b expected 200 0 1", pc, halted, valid); end
    redirect = 1'b0; halt = 1'b0;
    tick();
    nchk++; if (halted !== 1'b0 || pc !== 32'h200) begin nfail++; $display("FAIL redir_halt_drop: got halted=%b pc=%h expected 0 200", halted, pc); end
    halt = 1'b1;
    tick();
    halt = 1'b0; redirect = 1'b1; target = 32'h3;
    tick();
    nchk++; if (pc !== 32'h100 || mis !== 1'b1 || halted !== 1'b0) begin nfail++; $display("FAIL halt_misalign: got pc=%h mis=%b halted=%b expected 100 1 0", pc, mis, halted); end
    redirect = 1'b0;
    tick();
    nchk++; if (mis !== 1'b0 || pc !== 32'h100) begin nfail++; $display("FAIL halt_misalign_end: got mis=%b pc=%h expected 0 100", mis, pc); end
  endtask

  task automatic test_wrap8();
    redirect8 = 1'b1; target8 = 8'hFC;
    tick();
    nchk++; if (pc8 !== 8'hFC || pcplus8 !== 8'h00) begin nfail++; $display("FAIL w8_setup: got pc=%h pcplus=%h expected fc 00", pc8, pcplus8); end
    redirect8 = 1'b0; ready8 = 1'b1;
    tick();
    nchk++; if (pc8 !== 8'h00 || pcplus8 !== 8'h04 || cnt8 !== 2'd1) begin nfail++; $display("FAIL w8_pcwrap: got pc=%h pcplus=%h cnt=%0d expected 00 04 1", pc8, pcplus8, cnt8); end
    tick();
    tick();
    nchk++; if (pc8 !== 8'h08 || cnt8 !== 2'd3) begin nfail++; $display("FAIL w8_cnt3: got pc=%h cnt=%0d expected 08 3", pc8, cnt8); end
    tick();
    nchk++; if (pc8 !== 8'h0C || cnt8 !== 2'd0) begin nfail++; $display("FAIL w8_cntwrap: got pc=%h cnt=%0d expected 0c 0", pc8, cnt8); end
    trap8 = 1'b1;
    tick();
    nchk++; if (pc8 !== 8'h00 || cnt8 !== 2'd0) begin nfail++; $display("FAIL w8_trap_trunc: got pc=%h cnt=%0d expected 00 0", pc8, cnt8); end
    trap8 = 1'b0; ready8 = 1'b0;
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    tick();
    nchk++; if (pc !== 32'h104) begin nfail++; $display("FAIL pre_areset: got %h expected %h", pc, 32'h104); end
    rst_ni = 1'b0;
    #2;
    nchk++; if (pc !== 32'h0 || valid !== 1'b0 || cnt !== 16'd0 || halted !== 1'b0 || mis !== 1'b0) begin nfail++; $display("FAIL areset: got pc=%h valid=%b cnt=%0d halted=%b mis=%b expected all 0", pc, valid, cnt, halted, mis); end
    nchk++; if (pc8 !== 8'h00 || cnt8 !== 2'd0) begin nfail++; $display("FAIL areset8: got pc=%h cnt=%0d expected 00 0", pc8, cnt8); end
    tick();
    rst_ni = 1'b1;
    tick();
    nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL reboot_valid: got %b expected 0", valid); end
    tick();
    nchk++; if (valid !== 1'b1 || pc !== 32'h0) begin nfail++; $display("FAIL reboot_run: got valid=%b pc=%h expected 1 0", valid, pc); end
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap_redirect();
    test_halt();
    test_redirect_halt();
    test_wrap8();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter unit for the instruction-fetch stage of the monocycle and later pipelined cores. It holds the fetch address and advances it by a fixed increment when the consumer accepts it, with stall support. It redirects to branch/jump targets or a trap vector, detects misaligned targets, and has boot and halt states. A wrapping counter of accepted fetches is exposed for debug and performance measurement.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect (truncated to XLEN).
- INC, 4, increment per accepted fetch.
- ALIGN_BITS, 2, low target bits that must be zero.
- CNT_W, 16, width of the fetch counter.

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- fetch_ready_i  in  1  consumer (IMEM / IF-ID) accepts pc_o this cycle.
- stall_i  in  1  hold PC; suppresses advance.
- redirect_i  in  1  branch taken / jump.
- redirect_target_i  in  XLEN  redirect destination.
- trap_i  in  1  exception request.
- halt_i  in  1  enter HALT (ebreak/ecall stop).
- resume_i  in  1  leave HALT at the current PC.
- pc_o  out  XLEN  current fetch address (registered).
- pcplus_o  out  XLEN  pc_o + INC (combinational, modulo 2^XLEN).
- pc_valid_o  out  1  pc_o is a live fetch request.
- misalign_o  out  1  one-cycle registered pulse: misaligned redirect was converted to a trap.
- halted_o  out  1  state is HALT.
- fetch_cnt_o  out  CNT_W  count of accepted fetches.

## Operation
- States: BOOT, RUN, HALT.
- Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, halted_o=0, fetch_cnt_o=0, state BOOT.
- BOOT: lasts exactly one cycle after reset release, with pc_valid_o=0. Moves unconditionally to RUN and ignores all inputs.
- RUN: pc_valid_o=1. Each edge applies the first matching rule, in priority order:
  1. trap_i: pc_o←TRAP_VECTOR.
  2. redirect_i with redirect_target_i[ALIGN_BITS-1:0]≠0: pc_o←TRAP_VECTOR, misalign_o←1.
  3. redirect_i, aligned: pc_o←redirect_target_i.
  4. halt_i: go to HALT, pc_o held.
  5. fetch_ready_i && !stall_i: pc_o←pc_o+INC, wrapping modulo 2^XLEN.
  6. Otherwise hold.
- Redirects and traps do not depend on fetch_ready_i or stall_i. The in-flight fetch is discarded.
- fetch_cnt_o increments, wrapping, on each edge where state=RUN, pc_valid_o && fetch_ready_i && !stall_i, and no trap or redirect is applied. Halt does not block the count.
- HALT: pc_valid_o=0, halted_o=1.
  - trap_i or redirect_i: RUN with the new PC, applying the same priority and misalign rules as RUN.
  - Else resume_i: RUN with pc_o unchanged.
  - Else stay in HALT.
  - halt_i in HALT is ignored.
- misalign_o is 1 only in the cycle after the offending edge, otherwise 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any pending redirect is lost.

## Timing
- Registered PC: a redirect sampled at edge N is visible on pc_o after edge N. The unit has one cycle of redirect latency and no extra bubble.
- Sequential advance has zero bubbles. With fetch_ready_i=1 and stall_i=0, pc_o steps by INC every cycle.
- pcplus_o tracks pc_o combinationally in the same cycle.
- First valid fetch: pc_valid_o rises after the second edge following reset release, with pc_o=RESET_VECTOR.
- Simultaneous events:
  - trap_i+redirect_i: the trap wins, misalign_o=0.
  - redirect_i+halt_i: redirect applied, state stays RUN, and halt_i is dropped.
  - stall_i+redirect_i: redirect applied.

## Test plan
- Reset then fetch_ready_i=1: pc_valid_o=0 for 1 cycle. Then pc_o=0,4,8,12; fetch_cnt_o=0,1,2,3 on successive cycles.
- stall_i=1 for 3 cycles at pc_o=8 with fetch_ready_i=1: pc_o stays 8 and fetch_cnt_o is frozen. Release: pc_o=12 next cycle.
- redirect_i with target 0x40 while stall_i=1: pc_o=0x40 next cycle. Target 0x42: pc_o=0x100, misalign_o=1 for exactly one cycle.
- trap_i and redirect_i(0x80) together: pc_o=0x100, misalign_o=0.
- halt_i at pc_o=0x20: halted_o=1, pc_valid_o=0, pc_o stays 0x20 for 5 cycles. resume_i: RUN at 0x20. Repeat the halt and exit with redirect 0x60 instead: RUN at 0x60.
- Wrap checks:
  - XLEN=8, pc_o=0xFC, advance: pc_o=0x00, pcplus_o=0x04.
  - CNT_W=2: fetch_cnt_o wraps 3→0.
  - rst_ni pulsed low mid-run: pc_o=RESET_VECTOR asynchronously.
